// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, WAIT_CYCLES wait states, one-cycle response.
// Define DMEM_ERR_CHECK_EN to reject misaligned / out-of-range addresses; otherwise addresses wrap.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAST    = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH];

  logic          acc_now;
  logic          acc_write;
  logic          acc_err;
  logic          mem_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [29:0]   acc_word;
  logic [29:0]   acc_full;
  logic [AW-1:0] acc_idx;
  logic [31:0]   rd_word;
  logic [31:0]   rdata_next;
  logic          unused_bits;

  // With zero wait states the access happens on the accept edge, so it must use the live request.
  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  assign acc_now = (WAIT_CYCLES == 0) ? (state == IDLE && req_valid)
                                      : (state == WAIT && cnt == LAST);
  assign acc_word = acc_addr[31:2];

`ifdef DMEM_ERR_CHECK_EN
  assign acc_err  = (acc_addr[1:0] != 2'b00) || (acc_word >= DEPTH_W);
  assign acc_full = acc_word;
`else
  assign acc_err  = 1'b0;
  assign acc_full = acc_word % DEPTH_W;
`endif

  assign acc_idx     = acc_full[AW-1:0];
  assign unused_bits = ^{acc_full[29:AW], acc_addr[1:0]};

  // A reset arriving on the access edge cancels the write along with the request.
  assign mem_we = acc_now && acc_write && !acc_err && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign rd_word    = mem[acc_idx];
  assign rdata_next = (acc_write || acc_err) ? 32'd0 : rd_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (acc_now) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rdata_next;
              resp_err   <= acc_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (acc_now) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rdata_next;
            resp_err   <= acc_err;
          end
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed + randomized bench for dmem_responder (WAIT_CYCLES=2 instance and WAIT_CYCLES=0 instance),
// checked against a word-indexed memory model built from the addressing and error rules.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WAIT_CYCLES=2 instance
  logic        rst_a = 1'b1;
  logic        a_valid = 1'b0, a_write = 1'b0;
  logic [31:0] a_addr = 32'd0, a_wdata = 32'd0;
  logic        a_ready, a_resp_valid, a_err, a_busy;
  logic [31:0] a_rdata;

  // WAIT_CYCLES=0 instance
  logic        rst_z = 1'b1;
  logic        z_valid = 1'b0, z_write = 1'b0;
  logic [31:0] z_addr = 32'd0, z_wdata = 32'd0;
  logic        z_ready, z_resp_valid, z_err, z_busy;
  logic [31:0] z_rdata;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_rdata),
    .resp_err(a_err), .busy(a_busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst_z), .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
    .req_addr(z_addr), .req_wdata(z_wdata), .resp_valid(z_resp_valid), .resp_rdata(z_rdata),
    .resp_err(z_err), .busy(z_busy)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference memory: word index -> last successfully written value (absent = never written).
  logic [31:0] model_mem [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
    return (a[1:0] != 2'b00) || (int'(a[31:2]) >= DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_idx(input logic [31:0] a);
    return int'(a[31:2]) % DEPTH;
  endfunction

  task automatic tick_a();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance, checked against the model.
  task automatic run_a(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input string tag);
    int n;
    int lat;
    int idx;
    bit e;
    logic [31:0] rd;
    logic er;
    a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wd;
    n = 0;
    while (!a_ready && n < 20) begin
      tick_a();
      n++;
    end
    check({tag, " ready_before_accept"}, {31'd0, a_ready}, 32'd1);
    tick_a();
    // Accept edge passed: scramble the request fields, they must no longer matter.
    a_valid = 1'b0; a_write = 1'($urandom); a_addr = $urandom; a_wdata = $urandom;
    check({tag, " ready_low_after_accept"}, {31'd0, a_ready}, 32'd0);
    check({tag, " busy_after_accept"}, {31'd0, a_busy}, 32'd1);
    lat = 0;
    while (!a_resp_valid && lat < 20) begin
      tick_a();
      lat++;
    end
    rd = a_rdata;
    er = a_err;
    check({tag, " latency"}, 32'(lat), 32'd2);
    check({tag, " ready_low_in_resp"}, {31'd0, a_ready}, 32'd0);
    e   = exp_err(addr);
    idx = exp_idx(addr);
    check({tag, " err"}, {31'd0, er}, {31'd0, e});
    if (wr || e) check({tag, " rdata_zero"}, rd, 32'd0);
    else if (model_mem.exists(idx)) check({tag, " rdata"}, rd, model_mem[idx]);
    if (wr && !e) model_mem[idx] = wd;
    tick_a();
    check({tag, " resp_one_cycle"}, {31'd0, a_resp_valid}, 32'd0);
    check({tag, " ready_back"}, {31'd0, a_ready}, 32'd1);
    $display("txn %-14s %s addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             tag, wr ? "WR" : "RD", addr, wd, rd, er, lat);
  endtask

  // One transaction on the WAIT_CYCLES=0 instance (response visible right after the accept edge).
  task automatic run_z(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input string tag);
    z_valid = 1'b1; z_write = wr; z_addr = addr; z_wdata = wd;
    check({tag, " ready_before_accept"}, {31'd0, z_ready}, 32'd1);
    @(posedge clk); #1;
    z_valid = 1'b0; z_addr = $urandom; z_wdata = $urandom;
    check({tag, " resp_at_accept"}, {31'd0, z_resp_valid}, 32'd1);
    check({tag, " ready_low"}, {31'd0, z_ready}, 32'd0);
    check({tag, " rdata"}, z_rdata, exp_rd);
    check({tag, " err"}, {31'd0, z_err}, 32'd0);
    $display("txn %-14s %s addr=%h wdata=%h -> rdata=%h err=%0d lat=0",
             tag, wr ? "WR" : "RD", addr, wd, z_rdata, z_err);
    @(posedge clk); #1;
    check({tag, " resp_dropped"}, {31'd0, z_resp_valid}, 32'd0);
    check({tag, " ready_back"}, {31'd0, z_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_cyc [$];
    logic [31:0] resp_q [$];
    logic [31:0] v;
    logic [31:0] addr;
    bit rdy;
    int k;

    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_z = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      check("idle ready", {31'd0, a_ready}, 32'd1);
      check("idle busy", {31'd0, a_busy}, 32'd0);
      check("idle resp_valid", {31'd0, a_resp_valid}, 32'd0);
      check("idle rdata", a_rdata, 32'd0);
      check("idle z ready", {31'd0, z_ready}, 32'd1);
      tick_a();
    end

    // Write then read
    run_a(1'b1, 32'h10, 32'hDEADBEEF, "wr10");
    run_a(1'b0, 32'h10, 32'd0, "rd10");
    check("rd10 explicit", model_mem[4], 32'hDEADBEEF);

    // Back-pressure: preload, then hold req_valid across three reads
    for (int i = 0; i < 3; i++) run_a(1'b1, 32'(i * 4), $urandom, "preload");
    a_valid = 1'b1; a_write = 1'b0; a_addr = 32'h0;
    k = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      rdy = a_ready;
      tick_a();
      if (rdy && a_valid) begin
        acc_cyc.push_back(cyc);
        k++;
        if (k == 3) a_valid = 1'b0;
        else a_addr = 32'(k * 4);
      end
      if (a_resp_valid) resp_q.push_back(a_rdata);
    end
    a_valid = 1'b0;
    check("bp accepts", 32'(acc_cyc.size()), 32'd3);
    check("bp responses", 32'(resp_q.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      check("bp spacing1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
      check("bp spacing2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    end
    for (int i = 0; i < resp_q.size() && i < 3; i++) check("bp order", resp_q[i], model_mem[i]);
    $display("txn %-14s 3 held reads, accepts=%0d responses=%0d", "backpressure", acc_cyc.size(), resp_q.size());
    tick_a();

    // Reset mid-operation
    run_a(1'b1, 32'h20, 32'hAAAA0000, "preload20");
    a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h12345678;
    check("midrst ready", {31'd0, a_ready}, 32'd1);
    tick_a();
    a_valid = 1'b0;
    tick_a();
    rst_a = 1'b1;
    #1;
    check("midrst async ready", {31'd0, a_ready}, 32'd1);
    check("midrst async busy", {31'd0, a_busy}, 32'd0);
    check("midrst async resp_valid", {31'd0, a_resp_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick_a();
      check("midrst no resp", {31'd0, a_resp_valid}, 32'd0);
    end
    rst_a = 1'b0;
    $display("txn %-14s WR addr=00000020 wdata=12345678 discarded by reset", "midrst");
    tick_a();
    run_a(1'b0, 32'h20, 32'd0, "rd20");
    check("rd20 kept", model_mem[8], 32'hAAAA0000);

    // Misaligned / out-of-range writes, then read back the words they could alias
    run_a(1'b1, 32'h13, $urandom, "wr13");
    run_a(1'b1, 32'(DEPTH * 4), $urandom, "wr_depth");
    run_a(1'b1, 32'(DEPTH * 4 + 8), 32'hC0FFEE08, "wr_depth8");
    run_a(1'b0, 32'h10, 32'd0, "rd10_after");
    run_a(1'b0, 32'h0, 32'd0, "rd0_after");
    run_a(1'b0, 32'h8, 32'd0, "rd8_after");

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(7))
        0: addr = {$urandom_range(31), 2'b00} | 32'($urandom_range(1, 3));
        1: addr = 32'((DEPTH + $urandom_range(7)) * 4);
        default: addr = 32'($urandom_range(31) * 4);
      endcase
      run_a(1'($urandom_range(1)), addr, $urandom, "rand");
      repeat ($urandom_range(2)) tick_a();
    end

    // Zero-wait-state instance
    v = $urandom;
    run_z(1'b1, 32'h40, v, 32'd0, "z_wr40");
    run_z(1'b0, 32'h40, 32'd0, v, "z_rd40");
    run_z(1'b0, 32'h40, 32'd0, v, "z_rd40_again");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
